imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart to the read-only instruction memory.
- Receives a byte stream from a host or boot interface and assembles big-endian 32-bit instruction words; the first byte lands in [31:24], matching the fetch byte order of mem[PC]..mem[PC+3].
- Writes each word into the instruction memory write port at consecutive word addresses.
- Holds the CPU in reset while a load is in progress.

Parameters:
- ADDR_W, 10: instruction memory byte-address width (1024 bytes); addresses wrap modulo 2^ADDR_W.
- LEN_W, 9: width of the word-count field; maximum load is 2^LEN_W-1 words.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle load request; honoured only in IDLE.
- BASE_ADDR  in  ADDR_W  first word byte address, sampled on START; bits [1:0] forced to 0.
- LEN  in  LEN_W  number of words to load, sampled on START.
- ABORT  in  1  cancels the current load from any state.
- BYTE_IN  in  8  stream data.
- BYTE_VALID  in  1  stream data valid.
- BYTE_READY  out  1  loader can accept a byte.
- IM_WE  out  1  instruction memory write request.
- IM_ADDR  out  ADDR_W  word byte address.
- IM_WDATA  out  32  assembled instruction word.
- IM_WREADY  in  1  memory accepts the write this cycle.
- CPU_HOLD  out  1  keep the processor in reset while high.
- BUSY  out  1  load in progress.
- DONE  out  1  one-cycle pulse when a load completes normally.
- WORD_CNT  out  LEN_W  words written in the current or last load.
- CHECKSUM  out  8  XOR of all bytes accepted in the current or last load.

Behaviour:
- Reset (async, RESET_N=0): state IDLE; all outputs 0 (IM_ADDR=0, IM_WDATA=0, WORD_CNT=0, CHECKSUM=0); byte index and assembly register cleared.
- FSM states: IDLE, RECV, WRITE, FIN.
- IDLE:
  - BYTE_READY=0, BUSY=0, CPU_HOLD=0.
  - START with LEN!=0: latch address {BASE_ADDR[ADDR_W-1:2],2'b00}, remaining=LEN; clear WORD_CNT, CHECKSUM and byte index; go to RECV.
  - START with LEN==0: clear counters and go to FIN; no memory writes occur.
- RECV:
  - BYTE_READY=1, BUSY=1, CPU_HOLD=1.
  - A byte is accepted on a rising edge with BYTE_VALID&BYTE_READY.
  - Index 0 loads [31:24], 1 loads [23:16], 2 loads [15:8], 3 loads [7:0]; CHECKSUM ^= BYTE_IN.
  - On the 4th byte, the full word is registered to IM_WDATA, IM_WE=1 from the next cycle, and the state goes to WRITE.
- WRITE:
  - BYTE_READY=0; IM_WE, IM_ADDR and IM_WDATA held stable until a rising edge with IM_WREADY=1.
  - On that edge: IM_WE=0, IM_ADDR+=4 (wraps modulo 2^ADDR_W), WORD_CNT+=1, remaining-=1.
  - Next state is FIN if remaining reaches 0, otherwise RECV.
- FIN: DONE=1 for exactly one cycle, CPU_HOLD drops in the same cycle, BUSY=0; next state IDLE.
- Latency:
  - 4th byte accepted at edge N: IM_WE is high after N.
  - With IM_WREADY already high, the write completes at N+1 and BYTE_READY is high again after N+1.
  - Best-case rate is 5 cycles per word.
- ABORT:
  - Priority over everything except reset; any state goes to IDLE on the next edge.
  - The partial word is discarded, IM_WE drops, DONE is not pulsed, CPU_HOLD drops.
  - WORD_CNT and CHECKSUM keep their values.
- Edge cases:
  - START outside IDLE is ignored.
  - BYTE_VALID in IDLE, WRITE or FIN is not consumed.
  - A byte offered in the same cycle as ABORT is dropped.
  - Reset mid-load leaves the memory with the words already written; no rollback.

Decomposition:
- Shared package: state encoding constants (IDLE=0, RECV=1, WRITE=2, FIN=3) and the byte-lane order constant (big-endian, lane 0 = [31:24]), shared with the instruction memory model.
- One natural sub-module, imem_word_packer: byte index counter, shift/assembly register and checksum; reports word-complete.
- The FSM, address counter and word counter stay in the top level.

Test Plan:
- BASE_ADDR=0, LEN=1, bytes 00,01,10,20, IM_WREADY=1 -> one write IM_ADDR=0, IM_WDATA=32'h00011020; DONE pulse; WORD_CNT=1; CHECKSUM=8'h31.
- BASE_ADDR=0x2E (misaligned), LEN=2, 8 bytes -> writes at 0x2C and 0x30; CPU_HOLD high from the cycle after START until the DONE cycle.
- IM_WREADY held low 3 cycles on the first word -> IM_WE/IM_ADDR/IM_WDATA stable all 3 cycles; BYTE_READY=0 and extra BYTE_VALID bytes are not consumed.
- BASE_ADDR=0x3FC, LEN=2 -> second write at IM_ADDR=0x000 (wrap).
- ABORT after 2 bytes of the second word -> no second write, no DONE, state IDLE; WORD_CNT=1.
- START with LEN=0 -> DONE pulse 2 cycles after START, IM_WE never asserted; RESET_N pulled low mid-RECV -> all outputs 0 immediately.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction memory model:
// FSM state encoding and the big-endian byte-lane order.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    // Byte lane 0 sits at [31:24]; later lanes move down by 8 bits.
    localparam logic [4:0] LANE0_SHIFT = 5'd24;

    function automatic logic [31:0] place_byte(input logic [31:0] word,
                                               input logic [1:0]  idx,
                                               input logic [7:0]  data);
        logic [4:0] sh;
        sh = LANE0_SHIFT - {idx, 3'b000};
        return (word & ~(32'h0000_00ff << sh)) | ({24'h0, data} << sh);
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Assembles four stream bytes into one big-endian word and keeps a running XOR checksum.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        discard,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done,
    output logic [7:0]  checksum
);

    logic [1:0]  idx;
    logic [31:0] asm_q;

    // The completed word is presented combinationally so the caller can register it on the 4th byte.
    always_comb begin
        word      = place_byte(asm_q, idx, byte_in);
        word_done = accept && (idx == 2'd3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= 2'd0;
            asm_q    <= 32'h0;
            checksum <= 8'h0;
        end else if (clear || discard) begin
            idx   <= 2'd0;
            asm_q <= 32'h0;
            if (clear)
                checksum <= 8'h0;
        end else if (accept) begin
            idx      <= idx + 2'd1;
            asm_q    <= word_done ? 32'h0 : word;
            checksum <= checksum ^ byte_in;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into the instruction memory as big-endian words while holding the CPU in reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 9
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [LEN_W-1:0]  LEN,
    input  logic              ABORT,
    input  logic [7:0]        BYTE_IN,
    input  logic              BYTE_VALID,
    output logic              BYTE_READY,
    output logic              IM_WE,
    output logic [ADDR_W-1:0] IM_ADDR,
    output logic [31:0]       IM_WDATA,
    input  logic              IM_WREADY,
    output logic              CPU_HOLD,
    output logic              BUSY,
    output logic              DONE,
    output logic [LEN_W-1:0]  WORD_CNT,
    output logic [7:0]        CHECKSUM
);

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic             pk_clear;
    logic             pk_accept;
    logic [31:0]      pk_word;
    logic             pk_word_done;

    assign pk_clear  = (state == ST_IDLE) && START && !ABORT;
    // A byte arriving alongside ABORT is dropped.
    assign pk_accept = (state == ST_RECV) && BYTE_READY && BYTE_VALID && !ABORT;

    imem_word_packer u_packer (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .clear     (pk_clear),
        .discard   (ABORT),
        .accept    (pk_accept),
        .byte_in   (BYTE_IN),
        .word      (pk_word),
        .word_done (pk_word_done),
        .checksum  (CHECKSUM)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            BYTE_READY <= 1'b0;
            IM_WE      <= 1'b0;
            IM_ADDR    <= '0;
            IM_WDATA   <= 32'h0;
            CPU_HOLD   <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            WORD_CNT   <= '0;
        end else if (ABORT) begin
            state      <= ST_IDLE;
            BYTE_READY <= 1'b0;
            IM_WE      <= 1'b0;
            CPU_HOLD   <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        WORD_CNT <= '0;
                        if (LEN != '0) begin
                            IM_ADDR    <= BASE_ADDR & ~ADDR_W'(3);
                            remaining  <= LEN;
                            BYTE_READY <= 1'b1;
                            BUSY       <= 1'b1;
                            CPU_HOLD   <= 1'b1;
                            state      <= ST_RECV;
                        end else begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_RECV: begin
                    if (pk_word_done) begin
                        IM_WDATA   <= pk_word;
                        IM_WE      <= 1'b1;
                        BYTE_READY <= 1'b0;
                        state      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (IM_WREADY) begin
                        IM_WE     <= 1'b0;
                        IM_ADDR   <= IM_ADDR + ADDR_W'(4);
                        WORD_CNT  <= WORD_CNT + LEN_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= ST_FIN;
                        end else begin
                            BYTE_READY <= 1'b1;
                            state      <= ST_RECV;
                        end
                    end
                end
                ST_FIN: begin
                    DONE     <= 1'b1;
                    CPU_HOLD <= 1'b0;
                    BUSY     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        START = 1'b0;
    logic [9:0]  BASE_ADDR = '0;
    logic [8:0]  LEN = '0;
    logic        ABORT = 1'b0;
    logic [7:0]  BYTE_IN = '0;
    logic        BYTE_VALID = 1'b0;
    logic        BYTE_READY;
    logic        IM_WE;
    logic [9:0]  IM_ADDR;
    logic [31:0] IM_WDATA;
    logic        IM_WREADY = 1'b1;
    logic        CPU_HOLD;
    logic        BUSY;
    logic        DONE;
    logic [8:0]  WORD_CNT;
    logic [7:0]  CHECKSUM;

    int checks = 0;
    int errors = 0;

    logic [9:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          we_cycles = 0;
    int          done_cnt = 0;
    int          hold_drops = 0;
    logic        mon_hold = 1'b0;

    imem_loader #(.ADDR_W(10), .LEN_W(9)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .BASE_ADDR(BASE_ADDR), .LEN(LEN),
        .ABORT(ABORT), .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY),
        .IM_WE(IM_WE), .IM_ADDR(IM_ADDR), .IM_WDATA(IM_WDATA), .IM_WREADY(IM_WREADY),
        .CPU_HOLD(CPU_HOLD), .BUSY(BUSY), .DONE(DONE), .WORD_CNT(WORD_CNT), .CHECKSUM(CHECKSUM)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RESET_N && IM_WE && IM_WREADY) begin
            wr_addr.push_back(IM_ADDR);
            wr_data.push_back(IM_WDATA);
        end
    end

    always @(negedge CLK) begin
        if (IM_WE) we_cycles++;
        if (DONE) done_cnt++;
        if (mon_hold && !CPU_HOLD && !DONE) hold_drops++;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic start_load(input logic [9:0] base, input logic [8:0] len);
        BASE_ADDR = base;
        LEN = len;
        START = 1'b1;
        tick;
        START = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        BYTE_VALID = 1'b1;
        BYTE_IN = b;
        while (!BYTE_READY && n < 20) begin
            tick;
            n++;
        end
        if (!BYTE_READY) begin
            checks++; errors++;
            $display("FAIL byte_ready_timeout: byte %h never accepted", b);
        end else begin
            tick;
        end
        BYTE_VALID = 1'b0;
    endtask

    task automatic wait_done;
        int n = 0;
        while (!DONE && n < 40) begin
            tick;
            n++;
        end
        checks++;
        if (!DONE) begin
            errors++;
            $display("FAIL done_timeout: DONE not seen within 40 cycles");
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({BYTE_READY, IM_WE, IM_ADDR, IM_WDATA, CPU_HOLD, BUSY, DONE, WORD_CNT, CHECKSUM} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b addr=%h wdata=%h busy=%b cnt=%0d cks=%h, want all 0",
                     IM_WE, IM_ADDR, IM_WDATA, BUSY, WORD_CNT, CHECKSUM);
        end
        repeat (2) tick;
        RESET_N = 1'b1;
        tick;
    endtask

    task automatic test_single_word;
        int w0;
        w0 = wr_addr.size();
        IM_WREADY = 1'b1;
        start_load(10'h000, 9'd1);
        checks++;
        if ({BUSY, CPU_HOLD, BYTE_READY} !== 3'b111) begin
            errors++;
            $display("FAIL single_start: busy/hold/ready=%b want 111", {BUSY, CPU_HOLD, BYTE_READY});
        end
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h10); send_byte(8'h20);
        checks++;
        if ({IM_WE, BYTE_READY, IM_ADDR, IM_WDATA} !== {1'b1, 1'b0, 10'h000, 32'h00011020}) begin
            errors++;
            $display("FAIL single_word: we=%b rdy=%b addr=%h data=%h want 1 0 000 00011020",
                     IM_WE, BYTE_READY, IM_ADDR, IM_WDATA);
        end
        tick;
        checks++;
        if ({IM_WE, DONE, CPU_HOLD, WORD_CNT} !== {1'b0, 1'b0, 1'b1, 9'd1}) begin
            errors++;
            $display("FAIL single_after_write: we=%b done=%b hold=%b cnt=%0d want 0 0 1 1",
                     IM_WE, DONE, CPU_HOLD, WORD_CNT);
        end
        tick;
        checks++;
        if ({DONE, CPU_HOLD, BUSY, CHECKSUM} !== {1'b1, 1'b0, 1'b0, 8'h31}) begin
            errors++;
            $display("FAIL single_done: done=%b hold=%b busy=%b cks=%h want 1 0 0 31",
                     DONE, CPU_HOLD, BUSY, CHECKSUM);
        end
        tick;
        checks++;
        if (DONE !== 1'b0) begin
            errors++;
            $display("FAIL single_done_pulse: done=%b want 0", DONE);
        end
        checks++;
        if (wr_addr.size() != w0 + 1) begin
            errors++;
            $display("FAIL single_write_count: got %0d want 1", wr_addr.size() - w0);
        end else if (wr_addr[w0] !== 10'h000 || wr_data[w0] !== 32'h00011020) begin
            errors++;
            $display("FAIL single_write_value: addr=%h data=%h want 000 00011020", wr_addr[w0], wr_data[w0]);
        end
    endtask

    task automatic test_misaligned;
        int w0;
        w0 = wr_addr.size();
        hold_drops = 0;
        start_load(10'h02E, 9'd2);
        mon_hold = 1'b1;
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        wait_done;
        mon_hold = 1'b0;
        checks++;
        if (hold_drops != 0 || CPU_HOLD !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_hold: drops=%0d hold_at_done=%b want 0 0", hold_drops, CPU_HOLD);
        end
        checks++;
        if (wr_addr.size() != w0 + 2) begin
            errors++;
            $display("FAIL misaligned_count: got %0d want 2", wr_addr.size() - w0);
        end else if (wr_addr[w0] !== 10'h02C || wr_data[w0] !== 32'hDEADBEEF ||
                     wr_addr[w0+1] !== 10'h030 || wr_data[w0+1] !== 32'h12345678) begin
            errors++;
            $display("FAIL misaligned_writes: %h:%h %h:%h want 02c:deadbeef 030:12345678",
                     wr_addr[w0], wr_data[w0], wr_addr[w0+1], wr_data[w0+1]);
        end
        checks++;
        if ({WORD_CNT, CHECKSUM} !== {9'd2, 8'h2A}) begin
            errors++;
            $display("FAIL misaligned_stats: cnt=%0d cks=%h want 2 2a", WORD_CNT, CHECKSUM);
        end
        tick;
    endtask

    task automatic test_wready_stall;
        int w0;
        w0 = wr_addr.size();
        IM_WREADY = 1'b0;
        start_load(10'h100, 9'd1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        BYTE_VALID = 1'b1;
        BYTE_IN = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({IM_WE, BYTE_READY, IM_ADDR, IM_WDATA} !== {1'b1, 1'b0, 10'h100, 32'h11223344}) begin
                errors++;
                $display("FAIL stall_hold_%0d: we=%b rdy=%b addr=%h data=%h want 1 0 100 11223344",
                         i, IM_WE, BYTE_READY, IM_ADDR, IM_WDATA);
            end
            tick;
        end
        BYTE_VALID = 1'b0;
        IM_WREADY = 1'b1;
        wait_done;
        checks++;
        if ({WORD_CNT, CHECKSUM} !== {9'd1, 8'h44} || wr_addr.size() != w0 + 1) begin
            errors++;
            $display("FAIL stall_result: cnt=%0d cks=%h writes=%0d want 1 44 1",
                     WORD_CNT, CHECKSUM, wr_addr.size() - w0);
        end
        tick;
    endtask

    task automatic test_wrap;
        int w0;
        w0 = wr_addr.size();
        start_load(10'h3FC, 9'd2);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        wait_done;
        checks++;
        if (wr_addr.size() != w0 + 2) begin
            errors++;
            $display("FAIL wrap_count: got %0d want 2", wr_addr.size() - w0);
        end else if (wr_addr[w0] !== 10'h3FC || wr_data[w0] !== 32'h01020304 ||
                     wr_addr[w0+1] !== 10'h000 || wr_data[w0+1] !== 32'h05060708) begin
            errors++;
            $display("FAIL wrap_writes: %h:%h %h:%h want 3fc:01020304 000:05060708",
                     wr_addr[w0], wr_data[w0], wr_addr[w0+1], wr_data[w0+1]);
        end
        tick;
    endtask

    task automatic test_abort;
        int w0, d0;
        w0 = wr_addr.size();
        d0 = done_cnt;
        start_load(10'h040, 9'd2);
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        send_byte(8'hE5); send_byte(8'hF6);
        ABORT = 1'b1;
        BYTE_VALID = 1'b1;
        BYTE_IN = 8'h77;
        tick;
        ABORT = 1'b0;
        BYTE_VALID = 1'b0;
        checks++;
        if ({BUSY, CPU_HOLD, BYTE_READY, IM_WE, DONE} !== 5'b0) begin
            errors++;
            $display("FAIL abort_state: busy=%b hold=%b rdy=%b we=%b done=%b want all 0",
                     BUSY, CPU_HOLD, BYTE_READY, IM_WE, DONE);
        end
        repeat (4) tick;
        checks++;
        if ({WORD_CNT, CHECKSUM} !== {9'd1, 8'h17}) begin
            errors++;
            $display("FAIL abort_stats: cnt=%0d cks=%h want 1 17", WORD_CNT, CHECKSUM);
        end
        checks++;
        if (done_cnt != d0 || wr_addr.size() != w0 + 1) begin
            errors++;
            $display("FAIL abort_effects: dones=%0d writes=%0d want 0 1", done_cnt - d0, wr_addr.size() - w0);
        end
    endtask

    task automatic test_len_zero;
        int we0;
        we0 = we_cycles;
        start_load(10'h010, 9'd0);
        checks++;
        if (DONE !== 1'b0) begin
            errors++;
            $display("FAIL len0_early: done=%b want 0", DONE);
        end
        tick;
        checks++;
        if ({DONE, WORD_CNT, CHECKSUM} !== {1'b1, 9'd0, 8'h00}) begin
            errors++;
            $display("FAIL len0_done: done=%b cnt=%0d cks=%h want 1 0 00", DONE, WORD_CNT, CHECKSUM);
        end
        tick;
        checks++;
        if (DONE !== 1'b0 || we_cycles != we0) begin
            errors++;
            $display("FAIL len0_after: done=%b we_cycles=%0d want 0 0", DONE, we_cycles - we0);
        end
    endtask

    task automatic test_reset_mid;
        start_load(10'h080, 9'd3);
        send_byte(8'h5A); send_byte(8'hC3);
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({BYTE_READY, IM_WE, IM_ADDR, IM_WDATA, CPU_HOLD, BUSY, DONE, WORD_CNT, CHECKSUM} !== '0) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b addr=%h wdata=%h hold=%b busy=%b cnt=%0d cks=%h want all 0",
                     BYTE_READY, IM_ADDR, IM_WDATA, CPU_HOLD, BUSY, WORD_CNT, CHECKSUM);
        end
        tick;
        RESET_N = 1'b1;
        tick;
    endtask

    initial begin
        test_reset;
        test_single_word;
        test_misaligned;
        test_wready_stall;
        test_wrap;
        test_abort;
        test_len_zero;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
